// File: rtl/dump_ctrl_pkg.sv
// Shared types and default widths for the waveform-dump window controller.
package dump_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_DUMPING = 2'd2,
        ST_DONE    = 2'd3
    } dump_state_e;

    localparam int CYCLE_W_DEF = 64;
    localparam int LEN_W_DEF   = 32;
    localparam int TIMEOUT_DEF = 100000;

endpackage

// File: rtl/commit_watchdog.sv
// Counts commit-free cycles and raises a sticky flag once TIMEOUT is reached.
module commit_watchdog
    import dump_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic commit_valid,
    output logic timeout
);

    localparam int              CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] idle_cnt_r;
    logic [CNT_W-1:0] idle_cnt_next_s;
    logic             timeout_r;

    // Next commit-free count: clear on commit, saturate at the limit.
    always_comb begin
        idle_cnt_next_s = idle_cnt_r;
        if (commit_valid) begin
            idle_cnt_next_s = {CNT_W{1'b0}};
        end else if (idle_cnt_r == LIMIT) begin
            idle_cnt_next_s = idle_cnt_r;
        end else begin
            idle_cnt_next_s = idle_cnt_r + CNT_W'(1);
        end
    end

    // Counter and sticky flag; the flag rises on the edge the count hits the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_r <= {CNT_W{1'b0}};
            timeout_r  <= 1'b0;
        end else begin
            idle_cnt_r <= idle_cnt_next_s;
            timeout_r  <= timeout_r | (idle_cnt_next_s == LIMIT);
        end
    end

    assign timeout = timeout_r;

endmodule

// File: rtl/dump_window_ctrl.sv
// Opens a waveform-dump window on a cycle threshold or PC match, for a
// configurable number of cycles, alongside a commit watchdog.
module dump_window_ctrl
    import dump_ctrl_pkg::*;
#(
    parameter int CYCLE_W = CYCLE_W_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    input  logic [CYCLE_W-1:0] cfg_start_cycle,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_trig_en,
    input  logic [31:0]        cfg_trig_pc,
    input  logic               commit_valid,
    input  logic [31:0]        commit_pc,
    output logic               dump_on,
    output logic [CYCLE_W-1:0] cycle_count,
    output logic               timeout,
    output logic [1:0]         state
);

    dump_state_e        state_r;
    dump_state_e        state_next_s;
    logic [CYCLE_W-1:0] cycle_count_r;
    logic [CYCLE_W-1:0] start_cycle_r;
    logic [LEN_W-1:0]   len_r;
    logic [LEN_W-1:0]   len_cnt_r;
    logic               trig_en_r;
    logic [31:0]        trig_pc_r;
    logic               dump_on_r;
    logic               start_hit_s;
    logic               len_done_s;

    // Start condition for the armed window, evaluated against the latched config.
    always_comb begin
        start_hit_s = 1'b0;
        if (trig_en_r) begin
            start_hit_s = commit_valid && (commit_pc == trig_pc_r);
        end else begin
            start_hit_s = (cycle_count_r >= start_cycle_r);
        end
    end

    assign len_done_s = (len_r != {LEN_W{1'b0}}) && (len_cnt_r == len_r);

    // Next-state logic; a new configuration always wins over any start or end.
    always_comb begin
        state_next_s = state_r;
        if (cfg_valid) begin
            state_next_s = ST_ARMED;
        end else begin
            case (state_r)
                ST_IDLE:    state_next_s = ST_IDLE;
                ST_ARMED:   state_next_s = start_hit_s ? ST_DUMPING : ST_ARMED;
                ST_DUMPING: state_next_s = len_done_s ? ST_DONE : ST_DUMPING;
                ST_DONE:    state_next_s = ST_DONE;
                default:    state_next_s = ST_IDLE;
            endcase
        end
    end

    // State, free-running counter, config latch and window length counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            cycle_count_r <= {CYCLE_W{1'b0}};
            start_cycle_r <= {CYCLE_W{1'b0}};
            len_r         <= {LEN_W{1'b0}};
            len_cnt_r     <= {LEN_W{1'b0}};
            trig_en_r     <= 1'b0;
            trig_pc_r     <= 32'd0;
            dump_on_r     <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            cycle_count_r <= cycle_count_r + CYCLE_W'(1);
            dump_on_r     <= (state_next_s == ST_DUMPING);
            if (cfg_valid) begin
                start_cycle_r <= cfg_start_cycle;
                len_r         <= cfg_len;
                trig_en_r     <= cfg_trig_en;
                trig_pc_r     <= cfg_trig_pc;
            end else begin
                start_cycle_r <= start_cycle_r;
                len_r         <= len_r;
                trig_en_r     <= trig_en_r;
                trig_pc_r     <= trig_pc_r;
            end
            // Counter holds the number of dump_on cycles including the current one.
            if (state_next_s == ST_DUMPING) begin
                if (state_r == ST_DUMPING) begin
                    len_cnt_r <= len_cnt_r + LEN_W'(1);
                end else begin
                    len_cnt_r <= LEN_W'(1);
                end
            end else begin
                len_cnt_r <= {LEN_W{1'b0}};
            end
        end
    end

    commit_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk          (clk),
        .rst          (rst),
        .commit_valid (commit_valid),
        .timeout      (timeout)
    );

    assign dump_on     = dump_on_r;
    assign cycle_count = cycle_count_r;
    assign state       = state_r;

endmodule

// File: tb/tb_dump_window_ctrl.sv
// Directed bench for dump_window_ctrl: cycle mode, PC mode, past threshold,
// reconfiguration during a window, watchdog and mid-window reset.
module tb_dump_window_ctrl;
    import dump_ctrl_pkg::*;

    localparam int CW = 64;
    localparam int LW = 32;
    localparam int TO = 16;
    localparam logic [31:0] TRIG_PC = 32'h6000_0010;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid;
    logic [CW-1:0] cfg_start_cycle;
    logic [LW-1:0] cfg_len;
    logic          cfg_trig_en;
    logic [31:0]   cfg_trig_pc;
    logic          commit_valid;
    logic [31:0]   commit_pc;
    logic          dump_on;
    logic [CW-1:0] cycle_count;
    logic          timeout;
    logic [1:0]    state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    dump_window_ctrl #(
        .CYCLE_W (CW),
        .LEN_W   (LW),
        .TIMEOUT (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_valid       (cfg_valid),
        .cfg_start_cycle (cfg_start_cycle),
        .cfg_len         (cfg_len),
        .cfg_trig_en     (cfg_trig_en),
        .cfg_trig_pc     (cfg_trig_pc),
        .commit_valid    (commit_valid),
        .commit_pc       (commit_pc),
        .dump_on         (dump_on),
        .cycle_count     (cycle_count),
        .timeout         (timeout),
        .state           (state)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic load_cfg(input logic [CW-1:0] sc, input logic [LW-1:0] len,
                            input logic te, input logic [31:0] pc);
        cfg_valid       = 1'b1;
        cfg_start_cycle = sc;
        cfg_len         = len;
        cfg_trig_en     = te;
        cfg_trig_pc     = pc;
        step();
        cfg_valid       = 1'b0;
    endtask

    task automatic do_commit(input logic [31:0] pc);
        commit_valid = 1'b1;
        commit_pc    = pc;
        step();
        commit_valid = 1'b0;
        commit_pc    = 32'd0;
    endtask

    initial begin
        rst             = 1'b1;
        cfg_valid       = 1'b0;
        cfg_start_cycle = '0;
        cfg_len         = '0;
        cfg_trig_en     = 1'b0;
        cfg_trig_pc     = 32'd0;
        commit_valid    = 1'b0;
        commit_pc       = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;

        check_eq("rst_cycle", cycle_count, 64'd0);
        check_eq("rst_state", state, ST_IDLE);
        check_eq("rst_dump", dump_on, 1'b0);
        check_eq("rst_timeout", timeout, 1'b0);

        // Cycle mode: start 20, len 5, configured in cycle 3
        run_to(2);
        check_eq("idle_ignores", state, ST_IDLE);
        run_to(3);
        load_cfg(64'd20, 32'd5, 1'b0, 32'd0);
        check_eq("cyc_armed", state, ST_ARMED);
        for (int c = 4; c <= 30; c++) begin
            run_to(c);
            check_eq("cyc_dump", dump_on, (c >= 21 && c <= 25));
            check_eq("wd_timeout", timeout, (c >= 16));
        end
        check_eq("cyc_done", state, ST_DONE);
        check_eq("cyc_count", cycle_count, 64'd30);
        do_commit(32'h0000_1000);
        check_eq("wd_sticky", timeout, 1'b1);

        // PC mode: trigger at 0x60000010, len 0 (unbounded)
        run_to(35);
        load_cfg(64'd0, 32'd0, 1'b1, TRIG_PC);
        check_eq("pc_armed", state, ST_ARMED);
        run_to(38);
        do_commit(32'h6000_0014);
        check_eq("pc_nomatch_state", state, ST_ARMED);
        check_eq("pc_nomatch_dump", dump_on, 1'b0);
        run_to(40);
        check_eq("pc_pre_dump", dump_on, 1'b0);
        do_commit(TRIG_PC);
        check_eq("pc_dumping", state, ST_DUMPING);
        for (int c = 41; c <= 200; c++) begin
            run_to(c);
            check_eq("pc_dump_hold", dump_on, 1'b1);
        end
        check_eq("pc_count", cycle_count, 64'd200);

        // Reconfigure during the window coincident with a PC match
        run_to(201);
        commit_valid = 1'b1;
        commit_pc    = TRIG_PC;
        load_cfg(64'd0, 32'd0, 1'b1, TRIG_PC);
        commit_valid = 1'b0;
        commit_pc    = 32'd0;
        check_eq("recfg_dump", dump_on, 1'b0);
        check_eq("recfg_state", state, ST_ARMED);
        step();
        check_eq("recfg_hold_state", state, ST_ARMED);
        check_eq("recfg_hold_dump", dump_on, 1'b0);
        do_commit(TRIG_PC);
        check_eq("recfg_restart", dump_on, 1'b1);

        // Past threshold: start 5 applied at cycle 50, len 3
        rst = 1'b1;
        step();
        rst = 1'b0;
        cyc = 0;
        check_eq("rst2_timeout", timeout, 1'b0);
        check_eq("rst2_state", state, ST_IDLE);
        run_to(50);
        load_cfg(64'd5, 32'd3, 1'b0, 32'd0);
        check_eq("past_armed", state, ST_ARMED);
        check_eq("past_dump51", dump_on, 1'b0);
        for (int c = 52; c <= 56; c++) begin
            run_to(c);
            check_eq("past_dump", dump_on, (c <= 54));
        end
        check_eq("past_done", state, ST_DONE);

        // Reset mid-window, coincident with cfg_valid
        load_cfg(64'd0, 32'd0, 1'b0, 32'd0);
        run_to(59);
        check_eq("mid_dump", dump_on, 1'b1);
        check_eq("mid_timeout", timeout, 1'b1);
        run_to(60);
        rst       = 1'b1;
        cfg_valid = 1'b1;
        step();
        rst       = 1'b0;
        cfg_valid = 1'b0;
        cyc       = 0;
        check_eq("mid_rst_dump", dump_on, 1'b0);
        check_eq("mid_rst_state", state, ST_IDLE);
        check_eq("mid_rst_count", cycle_count, 64'd0);
        check_eq("mid_rst_timeout", timeout, 1'b0);
        run_to(3);
        check_eq("rst_wins_state", state, ST_IDLE);
        check_eq("rst_wins_dump", dump_on, 1'b0);
        check_eq("post_rst_count", cycle_count, 64'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dump_window_ctrl.md
DUMP_WINDOW_CTRL -- requirements
Module: dump_window_ctrl

Interface
REQ-001 Parameter CYCLE_W, default 64: width of the free-running cycle counter.
REQ-002 Parameter LEN_W, default 32: width of the window-length field.
REQ-003 Parameter TIMEOUT, default 100000: consecutive commit-free cycles before the watchdog fires.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 cfg_valid  input  1  one-cycle pulse loading a new dump configuration.
REQ-007 cfg_start_cycle  input  CYCLE_W  cycle-mode start threshold.
REQ-008 cfg_len  input  LEN_W  window length in cycles; 0 = unbounded.
REQ-009 cfg_trig_en  input  1  1 = start on PC match, 0 = start on cycle threshold.
REQ-010 cfg_trig_pc  input  32  PC-mode trigger address.
REQ-011 commit_valid  input  1  one instruction retired this cycle.
REQ-012 commit_pc  input  32  PC of the retiring instruction, valid with commit_valid.
REQ-013 dump_on  output  1  waveform-dump enable, registered.
REQ-014 cycle_count  output  CYCLE_W  cycles elapsed since reset.
REQ-015 timeout  output  1  sticky watchdog flag, registered.
REQ-016 state  output  2  current FSM state, for debug.

Function
REQ-017 The FSM SHALL have states IDLE, ARMED, DUMPING and DONE.
REQ-018 cycle_count SHALL increment by 1 every cycle, wrap modulo 2^CYCLE_W, and never pause.
REQ-019 cfg_valid SHALL latch all cfg_* fields and move the FSM to ARMED on the next edge from any state.
REQ-020 If cfg_valid is applied while in DUMPING, dump_on SHALL deassert on that same next edge.
REQ-021 ARMED, cycle mode: the start condition SHALL be cycle_count >= latched start_cycle (unsigned), so a threshold already in the past starts immediately.
REQ-022 ARMED, PC mode: the start condition SHALL be commit_valid && commit_pc == latched trig_pc.
REQ-023 When the start condition is true, the FSM SHALL enter DUMPING and dump_on SHALL be 1 from the next edge (latency 1).
REQ-024 In DUMPING, a length counter SHALL count cycles with dump_on = 1, starting at 1 in the first such cycle.
REQ-025 When the counter equals a nonzero latched len, the FSM SHALL enter DONE, so dump_on is high for exactly len cycles.
REQ-026 With len = 0, DUMPING SHALL persist until the next cfg_valid or rst.
REQ-027 DONE SHALL hold dump_on = 0 until cfg_valid; IDLE SHALL ignore commits and cycle thresholds.
REQ-028 If cfg_valid and a start condition occur in the same cycle, cfg_valid SHALL win; the start is re-evaluated against the new config from the following cycle.
REQ-029 A commit-free counter SHALL clear on each commit_valid and increment otherwise, saturating at TIMEOUT.
REQ-030 timeout SHALL assert on the edge at which the commit-free counter reaches TIMEOUT and stay 1 until rst; it SHALL NOT affect dump_on.

Reset
REQ-031 On rst the block SHALL set: FSM = IDLE; dump_on = 0; timeout = 0; cycle_count = 0; length and commit-free counters = 0; latched config = 0.
REQ-032 rst SHALL override cfg_valid and any start condition in the same cycle.
REQ-033 rst asserted mid-window SHALL drop dump_on on the next edge.

Structure
REQ-034 A shared package dump_ctrl_pkg SHALL hold the FSM state enum (2-bit) and the default width constants.
REQ-035 The watchdog SHALL be a sub-module commit_watchdog (clk, rst, commit_valid, timeout), parameterised by TIMEOUT.
REQ-036 All outputs SHALL be driven directly from flops.

Verification
REQ-037 Cycle mode: cfg start=20, len=5 at cycle 3 -> dump_on = 1 for exactly cycles 21..25, state = DONE afterwards.
REQ-038 PC mode: trig_pc=0x60000010, commit at that PC in cycle 40 -> dump_on = 1 from cycle 41; with len=0 it stays 1 through cycle 200.
REQ-039 Past threshold: cfg start=5 applied at cycle 50 -> ARMED at 51, dump_on = 1 at 52.
REQ-040 cfg_valid while DUMPING coincident with a PC match -> dump_on = 0 the next cycle, state = ARMED, no restart that cycle.
REQ-041 TIMEOUT=16, no commits for 16 cycles -> timeout = 1 and sticky; a later commit leaves it 1; rst clears it.
REQ-042 rst pulsed during DUMPING -> next cycle dump_on = 0, state = IDLE, cycle_count = 0.
